// File: rtl/ic19_pkg.sv
// ic19_pkg: shared constants and types for the piano board gate array.
// Holds the CPU address map windows, the IC12 scan address prefix,
// the scan counter width and the IC12 arbitration mode type.
package ic19_pkg;

    localparam int          CNT_W       = 4;
    localparam logic [2:0]  SCAN_PREFIX = 3'b111;

    localparam logic [15:0] RAM_LO  = 16'h0800;
    localparam logic [15:0] RAM_HI  = 16'h0FFF;
    localparam logic [15:0] IC12_LO = 16'h1000;
    localparam logic [15:0] IC12_HI = 16'h17FF;
    localparam logic [15:0] IO_LO   = 16'h2000;
    localparam logic [15:0] IO_HI   = 16'h26FF;
    localparam logic [15:0] IO2_HI  = 16'h20FF;
    localparam logic [15:0] ACK_LO  = 16'h2700;
    localparam logic [15:0] ACK_HI  = 16'h27FF;
    localparam logic [15:0] ROM_LO  = 16'h4000;
    localparam logic [15:0] ROM_HI  = 16'h7FFF;

    // Who owns IC12 this cycle: the frame scan or a CPU read/write.
    typedef enum logic [1:0] {
        IC12_SCAN,
        IC12_CPU_READ,
        IC12_CPU_WRITE
    } ic12_mode_e;

    function automatic logic in_window(input logic [15:0] a,
                                       input logic [15:0] lo,
                                       input logic [15:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

endpackage

// File: rtl/ic19_addr_decode.sv
// ic19_addr_decode: combinational decode of the latched CPU address.
// Nothing is selected unless the registered E phase is active; IO strobe
// bit 0 corresponds to IO2, bit 6 to IO8.
module ic19_addr_decode
    import ic19_pkg::*;
(
    input  logic [15:0] addr,
    input  logic        e,
    input  logic        rw,
    output logic        ram_sel,
    output logic        rom_sel,
    output logic [6:0]  io_sel,
    output logic        irq_ack,
    output logic        io2_wr,
    output ic12_mode_e  ic12_mode
);

    // Map the address onto exactly one device window while E is high.
    always_comb begin
        ram_sel   = 1'b0;
        rom_sel   = 1'b0;
        io_sel    = 7'b0;
        irq_ack   = 1'b0;
        io2_wr    = 1'b0;
        ic12_mode = IC12_SCAN;
        if (e) begin
            ram_sel = in_window(addr, RAM_LO, RAM_HI);
            rom_sel = in_window(addr, ROM_LO, ROM_HI);
            irq_ack = in_window(addr, ACK_LO, ACK_HI);
            io2_wr  = ~rw & in_window(addr, IO_LO, IO2_HI);
            if (in_window(addr, IO_LO, IO_HI)) begin
                io_sel = 7'b1 << addr[10:8];
            end
            if (in_window(addr, IC12_LO, IC12_HI)) begin
                ic12_mode = rw ? IC12_CPU_READ : IC12_CPU_WRITE;
            end
        end
    end

endmodule

// File: rtl/ic19_gate_array.sv
// ic19_gate_array: bus glue for the piano sound board.
// Latches the multiplexed CPU address, decodes selects and IO strobes,
// shares IC12 between the CPU and the frame scan counters, and raises the
// frame IRQ. Defining IC19_DEBUG_COUNTERS_EN exposes the scan counters.
module ic19_gate_array
    import ic19_pkg::*;
(
    input  logic        SYNC_IN,
    input  logic        RESET_IN,
    input  logic        FSYNC_IN,
    input  logic        E_IN,
    input  logic        RW_IN,
    input  logic        AS_IN,
    input  logic [7:0]  CPU_P3_IN,
    input  logic [7:0]  CPU_P4_IN,
    output logic [7:0]  CPU_P3_OUT,
    output logic        CPU_P3_IOM,
    input  logic [7:0]  AL_IN,
    output logic [7:0]  AL_OUT,
    output logic        AL0_IOM,
    output logic        RD_OUT,
    output logic        WR_OUT,
    output logic        PARAM_ROMCS_OUT,
    output logic        RAMCS_OUT,
    input  logic [7:0]  RIC12_D_IN,
    output logic [7:0]  RIC12_D_OUT,
    output logic        RIC12_D_IOM,
    output logic [10:0] RIC12_A_OUT,
    output logic        RIC12_OE_OUT,
    output logic        RIC12_WE_OUT,
    input  logic [7:0]  RIC13_D_IN,
    output logic [7:0]  RIC13_D_OUT,
    output logic        RIC13_D_IOM,
    output logic        IO2_OUT,
    output logic        IO3_OUT,
    output logic        IO4_OUT,
    output logic        IO5_OUT,
    output logic        IO6_OUT,
    output logic        IO7_OUT,
    output logic        IO8_OUT,
    output logic        IRQ_OUT,
    output logic        P1_TOVERFLOW,
    input  logic        E_NOR_77_IN,
    input  logic        AL_CT_76_IN,
    input  logic        UNK_75_IN,
    input  logic        UNK_74_IN
`ifdef IC19_DEBUG_COUNTERS_EN
    ,
    output logic [3:0]  COUNTER_OUT_C13,
    output logic [3:0]  COUNTER_OUT_F13
`endif
);

    logic [15:0]      addr_q;
    logic             as_prev;
    logic             e_q;
    logic             rw_q;
    logic             fsync_prev;
    logic             fsync_rise;
    logic [CNT_W-1:0] c13;
    logic [CNT_W-1:0] f13;
    logic [6:0]       io_n_q;

    logic             ram_sel;
    logic             rom_sel;
    logic [6:0]       io_sel;
    logic             irq_ack;
    logic             io2_wr;
    ic12_mode_e       ic12_mode;

    logic             unused_inputs;

    assign unused_inputs = ^{AL_IN, RIC13_D_IN, E_NOR_77_IN, AL_CT_76_IN,
                             UNK_75_IN, UNK_74_IN};

    assign fsync_rise = FSYNC_IN & ~fsync_prev;
    assign AL_OUT     = addr_q[7:0];
    assign AL0_IOM    = 1'b0;
    assign {IO8_OUT, IO7_OUT, IO6_OUT, IO5_OUT,
            IO4_OUT, IO3_OUT, IO2_OUT} = io_n_q;

`ifdef IC19_DEBUG_COUNTERS_EN
    assign COUNTER_OUT_C13 = c13;
    assign COUNTER_OUT_F13 = f13;
`endif

    ic19_addr_decode u_decode (
        .addr      (addr_q),
        .e         (e_q),
        .rw        (rw_q),
        .ram_sel   (ram_sel),
        .rom_sel   (rom_sel),
        .io_sel    (io_sel),
        .irq_ack   (irq_ack),
        .io2_wr    (io2_wr),
        .ic12_mode (ic12_mode)
    );

    // Capture the bus phase and latch the address on the AS falling edge.
    always_ff @(posedge SYNC_IN) begin
        if (RESET_IN) begin
            addr_q     <= 16'h0000;
            as_prev    <= 1'b1;
            e_q        <= 1'b0;
            rw_q       <= 1'b0;
            fsync_prev <= 1'b0;
        end else begin
            as_prev    <= AS_IN;
            e_q        <= E_IN;
            rw_q       <= RW_IN;
            fsync_prev <= FSYNC_IN;
            if (as_prev && !AS_IN) begin
                addr_q <= {CPU_P4_IN, CPU_P3_IN};
            end
        end
    end

    // Free-running sample counter, frame counter, overflow pulse and IRQ.
    always_ff @(posedge SYNC_IN) begin
        if (RESET_IN) begin
            c13          <= '0;
            f13          <= '0;
            P1_TOVERFLOW <= 1'b0;
            IRQ_OUT      <= 1'b1;
        end else begin
            c13          <= c13 + 1'b1;
            P1_TOVERFLOW <= fsync_rise && (f13 == 4'hF);
            if (fsync_rise) begin
                f13 <= f13 + 1'b1;
            end
            if (irq_ack) begin
                IRQ_OUT <= 1'b1;
            end else if (fsync_rise) begin
                IRQ_OUT <= 1'b0;
            end
        end
    end

    // Register the bus strobes, chip selects and the IC13 sample latch.
    always_ff @(posedge SYNC_IN) begin
        if (RESET_IN) begin
            RD_OUT          <= 1'b1;
            WR_OUT          <= 1'b1;
            RAMCS_OUT       <= 1'b1;
            PARAM_ROMCS_OUT <= 1'b1;
            io_n_q          <= 7'h7F;
            RIC13_D_OUT     <= 8'h00;
            RIC13_D_IOM     <= 1'b1;
        end else begin
            RD_OUT          <= ~(e_q & rw_q);
            WR_OUT          <= ~(e_q & ~rw_q);
            RAMCS_OUT       <= ~ram_sel;
            PARAM_ROMCS_OUT <= ~rom_sel;
            io_n_q          <= ~io_sel;
            RIC13_D_IOM     <= 1'b0;
            if (io2_wr) begin
                RIC13_D_OUT <= CPU_P3_IN;
            end
        end
    end

    // Give IC12 to the CPU during its window, otherwise run the frame scan.
    always_ff @(posedge SYNC_IN) begin
        if (RESET_IN) begin
            RIC12_A_OUT  <= 11'h000;
            RIC12_OE_OUT <= 1'b1;
            RIC12_WE_OUT <= 1'b1;
            RIC12_D_IOM  <= 1'b1;
            RIC12_D_OUT  <= 8'h00;
            CPU_P3_OUT   <= 8'h00;
            CPU_P3_IOM   <= 1'b1;
        end else begin
            case (ic12_mode)
                IC12_CPU_READ: begin
                    RIC12_A_OUT  <= addr_q[10:0];
                    RIC12_OE_OUT <= 1'b0;
                    RIC12_WE_OUT <= 1'b1;
                    RIC12_D_IOM  <= 1'b1;
                    CPU_P3_OUT   <= RIC12_D_IN;
                    CPU_P3_IOM   <= 1'b0;
                end
                IC12_CPU_WRITE: begin
                    RIC12_A_OUT  <= addr_q[10:0];
                    RIC12_OE_OUT <= 1'b1;
                    RIC12_WE_OUT <= 1'b0;
                    RIC12_D_IOM  <= 1'b0;
                    RIC12_D_OUT  <= CPU_P3_IN;
                    CPU_P3_IOM   <= 1'b1;
                end
                default: begin
                    RIC12_A_OUT  <= {SCAN_PREFIX, f13, c13};
                    RIC12_OE_OUT <= 1'b0;
                    RIC12_WE_OUT <= 1'b1;
                    RIC12_D_IOM  <= 1'b1;
                    CPU_P3_IOM   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ic19_gate_array.sv
// tb_ic19_gate_array: self-checking bench for the piano board gate array.
// A cycle model built from the address map compares every output each
// cycle, and directed bus cycles add hand-computed literal checks.
module tb_ic19_gate_array;

    logic        SYNC_IN = 1'b0;
    logic        RESET_IN, FSYNC_IN, E_IN, RW_IN, AS_IN;
    logic [7:0]  CPU_P3_IN, CPU_P4_IN, AL_IN, RIC12_D_IN, RIC13_D_IN;
    logic        E_NOR_77_IN, AL_CT_76_IN, UNK_75_IN, UNK_74_IN;

    logic [7:0]  CPU_P3_OUT, AL_OUT, RIC12_D_OUT, RIC13_D_OUT;
    logic        CPU_P3_IOM, AL0_IOM, RD_OUT, WR_OUT, PARAM_ROMCS_OUT, RAMCS_OUT;
    logic        RIC12_D_IOM, RIC12_OE_OUT, RIC12_WE_OUT, RIC13_D_IOM;
    logic [10:0] RIC12_A_OUT;
    logic        IO2_OUT, IO3_OUT, IO4_OUT, IO5_OUT, IO6_OUT, IO7_OUT, IO8_OUT;
    logic        IRQ_OUT, P1_TOVERFLOW;
`ifdef IC19_DEBUG_COUNTERS_EN
    logic [3:0]  COUNTER_OUT_C13, COUNTER_OUT_F13;
`endif

    int errors = 0;
    int checks = 0;

    ic19_gate_array dut (
        .SYNC_IN(SYNC_IN), .RESET_IN(RESET_IN), .FSYNC_IN(FSYNC_IN),
        .E_IN(E_IN), .RW_IN(RW_IN), .AS_IN(AS_IN),
        .CPU_P3_IN(CPU_P3_IN), .CPU_P4_IN(CPU_P4_IN),
        .CPU_P3_OUT(CPU_P3_OUT), .CPU_P3_IOM(CPU_P3_IOM),
        .AL_IN(AL_IN), .AL_OUT(AL_OUT), .AL0_IOM(AL0_IOM),
        .RD_OUT(RD_OUT), .WR_OUT(WR_OUT),
        .PARAM_ROMCS_OUT(PARAM_ROMCS_OUT), .RAMCS_OUT(RAMCS_OUT),
        .RIC12_D_IN(RIC12_D_IN), .RIC12_D_OUT(RIC12_D_OUT),
        .RIC12_D_IOM(RIC12_D_IOM), .RIC12_A_OUT(RIC12_A_OUT),
        .RIC12_OE_OUT(RIC12_OE_OUT), .RIC12_WE_OUT(RIC12_WE_OUT),
        .RIC13_D_IN(RIC13_D_IN), .RIC13_D_OUT(RIC13_D_OUT),
        .RIC13_D_IOM(RIC13_D_IOM),
        .IO2_OUT(IO2_OUT), .IO3_OUT(IO3_OUT), .IO4_OUT(IO4_OUT),
        .IO5_OUT(IO5_OUT), .IO6_OUT(IO6_OUT), .IO7_OUT(IO7_OUT),
        .IO8_OUT(IO8_OUT),
        .IRQ_OUT(IRQ_OUT), .P1_TOVERFLOW(P1_TOVERFLOW),
        .E_NOR_77_IN(E_NOR_77_IN), .AL_CT_76_IN(AL_CT_76_IN),
        .UNK_75_IN(UNK_75_IN), .UNK_74_IN(UNK_74_IN)
`ifdef IC19_DEBUG_COUNTERS_EN
        ,
        .COUNTER_OUT_C13(COUNTER_OUT_C13), .COUNTER_OUT_F13(COUNTER_OUT_F13)
`endif
    );

    always #5 SYNC_IN = ~SYNC_IN;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of bus inputs, then advance to the next falling edge.
    task automatic applyStimulus(input logic as, input logic e, input logic rw,
                                 input logic [7:0] p3, input logic [7:0] p4,
                                 input logic fs);
        AS_IN     = as;
        E_IN      = e;
        RW_IN     = rw;
        CPU_P3_IN = p3;
        CPU_P4_IN = p4;
        FSYNC_IN  = fs;
        @(negedge SYNC_IN);
    endtask

    // Address phase, AS fall, then E high for two cycles; returns once the
    // access is visible on the registered outputs.
    task automatic busCycle(input logic [15:0] a, input logic rw,
                            input logic [7:0] data, input logic fs_late);
        applyStimulus(1'b1, 1'b0, rw, a[7:0], a[15:8], 1'b0);
        applyStimulus(1'b0, 1'b0, rw, a[7:0], a[15:8], 1'b0);
        applyStimulus(1'b0, 1'b1, rw, data, a[15:8], 1'b0);
        applyStimulus(1'b0, 1'b1, rw, data, a[15:8], fs_late);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
    endtask

    // ---------------- behavioural model ----------------
    bit   m_valid = 0;
    int   m_addr, m_c13, m_f13;
    bit   m_e, m_rw, m_as_prev, m_fs_prev, m_irq;
    logic [7:0]  m_p3_out, m_d_out, m_r13_out;
    logic [10:0] x_a;
    logic [6:0]  x_io;
    logic        x_rd, x_wr, x_ram, x_rom, x_oe, x_we, x_diom, x_p3iom, x_tov, x_r13iom;

    function automatic bit inside_range(input int a, input int lo, input int hi);
        return (a >= lo) && (a <= hi);
    endfunction

    task modelStep();
        bit rise, ack, ic12;
        if (RESET_IN) begin
            m_valid = 1; m_addr = 0; m_e = 0; m_rw = 0; m_as_prev = 1; m_fs_prev = 0;
            m_c13 = 0; m_f13 = 0; m_irq = 1;
            m_p3_out = 0; m_d_out = 0; m_r13_out = 0;
            x_a = 0; x_io = 7'h7F; x_rd = 1; x_wr = 1; x_ram = 1; x_rom = 1;
            x_oe = 1; x_we = 1; x_diom = 1; x_p3iom = 1; x_tov = 0; x_r13iom = 1;
        end else begin
            rise  = FSYNC_IN && !m_fs_prev;
            ack   = m_e && inside_range(m_addr, 'h2700, 'h27FF);
            ic12  = m_e && inside_range(m_addr, 'h1000, 'h17FF);
            x_rd  = !(m_e && m_rw);
            x_wr  = !(m_e && !m_rw);
            x_ram = !(m_e && inside_range(m_addr, 'h0800, 'h0FFF));
            x_rom = !(m_e && inside_range(m_addr, 'h4000, 'h7FFF));
            x_io  = 7'h7F;
            if (m_e && inside_range(m_addr, 'h2000, 'h26FF))
                x_io[(m_addr - 'h2000) / 256] = 1'b0;
            if (ic12 && m_rw) begin
                x_a = 11'(m_addr % 2048); x_oe = 0; x_we = 1; x_diom = 1; x_p3iom = 0;
                m_p3_out = RIC12_D_IN;
            end else if (ic12) begin
                x_a = 11'(m_addr % 2048); x_oe = 1; x_we = 0; x_diom = 0; x_p3iom = 1;
                m_d_out = CPU_P3_IN;
            end else begin
                x_a = 11'('h700 + m_f13 * 16 + m_c13); x_oe = 0; x_we = 1; x_diom = 1; x_p3iom = 1;
            end
            if (m_e && !m_rw && inside_range(m_addr, 'h2000, 'h20FF)) m_r13_out = CPU_P3_IN;
            x_tov = rise && (m_f13 == 15);
            if (ack) m_irq = 1;
            else if (rise) m_irq = 0;
            m_c13 = (m_c13 + 1) % 16;
            if (rise) m_f13 = (m_f13 + 1) % 16;
            if (m_as_prev && !AS_IN) m_addr = CPU_P4_IN * 256 + CPU_P3_IN;
            m_as_prev = AS_IN; m_e = E_IN; m_rw = RW_IN; m_fs_prev = FSYNC_IN;
            x_r13iom = 0;
        end
    endtask

    // Compare every output against the model just after each rising edge.
    initial begin
        forever begin
            @(posedge SYNC_IN);
            modelStep();
            #1;
            if (m_valid) begin
                checkOutput("al_out", AL_OUT, 32'(m_addr % 256));
                checkOutput("al0_iom", AL0_IOM, 0);
                checkOutput("rd", RD_OUT, x_rd);
                checkOutput("wr", WR_OUT, x_wr);
                checkOutput("ramcs", RAMCS_OUT, x_ram);
                checkOutput("romcs", PARAM_ROMCS_OUT, x_rom);
                checkOutput("io_strobes", {IO8_OUT, IO7_OUT, IO6_OUT, IO5_OUT, IO4_OUT, IO3_OUT, IO2_OUT}, x_io);
                checkOutput("ic12_a", RIC12_A_OUT, x_a);
                checkOutput("ic12_oe", RIC12_OE_OUT, x_oe);
                checkOutput("ic12_we", RIC12_WE_OUT, x_we);
                checkOutput("ic12_d_iom", RIC12_D_IOM, x_diom);
                checkOutput("ic12_d_out", RIC12_D_OUT, m_d_out);
                checkOutput("p3_out", CPU_P3_OUT, m_p3_out);
                checkOutput("p3_iom", CPU_P3_IOM, x_p3iom);
                checkOutput("ic13_d_out", RIC13_D_OUT, m_r13_out);
                checkOutput("ic13_d_iom", RIC13_D_IOM, x_r13iom);
                checkOutput("irq", IRQ_OUT, m_irq);
                checkOutput("tovf", P1_TOVERFLOW, x_tov);
`ifdef IC19_DEBUG_COUNTERS_EN
                checkOutput("dbg_c13", COUNTER_OUT_C13, m_c13);
                checkOutput("dbg_f13", COUNTER_OUT_F13, m_f13);
`endif
            end
        end
    end

    // Directed stimulus with hand-computed literal expectations.
    initial begin
        int pulses;
        RESET_IN = 1; FSYNC_IN = 0; E_IN = 0; RW_IN = 1; AS_IN = 1;
        CPU_P3_IN = 0; CPU_P4_IN = 0; AL_IN = 8'hFF; RIC13_D_IN = 8'hFF;
        RIC12_D_IN = 8'h3C;
        E_NOR_77_IN = 0; AL_CT_76_IN = 0; UNK_75_IN = 0; UNK_74_IN = 0;
        repeat (3) @(negedge SYNC_IN);
        checkOutput("rst_ic12_a", RIC12_A_OUT, 11'h000);
        checkOutput("rst_ic13_iom", RIC13_D_IOM, 1);
        checkOutput("rst_irq", IRQ_OUT, 1);
        checkOutput("rst_p3_iom", CPU_P3_IOM, 1);

        RESET_IN = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge SYNC_IN);
            checkOutput("scan_count", RIC12_A_OUT, 11'h700 + 11'(k));
        end

        busCycle(16'h1005, 1'b1, 8'h00, 1'b0);
        checkOutput("rd_1005_a", RIC12_A_OUT, 11'h005);
        checkOutput("rd_1005_oe", RIC12_OE_OUT, 0);
        checkOutput("rd_1005_data", CPU_P3_OUT, 8'h3C);
        checkOutput("rd_1005_al", AL_OUT, 8'h05);
        checkOutput("rd_1005_p3iom", CPU_P3_IOM, 0);
        idle(2);
        checkOutput("idle_oe", RIC12_OE_OUT, 0);
        checkOutput("idle_p3iom", CPU_P3_IOM, 1);
        checkOutput("idle_prefix", RIC12_A_OUT[10:8], 3'b111);

        busCycle(16'h1005, 1'b0, 8'hA5, 1'b0);
        checkOutput("wr_1005_we", RIC12_WE_OUT, 0);
        checkOutput("wr_1005_diom", RIC12_D_IOM, 0);
        checkOutput("wr_1005_data", RIC12_D_OUT, 8'hA5);
        checkOutput("wr_1005_wr", WR_OUT, 0);
        idle(2);

        busCycle(16'h2000, 1'b1, 8'h00, 1'b0);
        checkOutput("io2", IO2_OUT, 0);
        idle(2);
        busCycle(16'h2300, 1'b1, 8'h00, 1'b0);
        checkOutput("io5", {IO8_OUT, IO7_OUT, IO6_OUT, IO5_OUT, IO4_OUT, IO3_OUT, IO2_OUT}, 7'b1110111);
        idle(2);
        busCycle(16'h26FF, 1'b1, 8'h00, 1'b0);
        checkOutput("io8", IO8_OUT, 0);
        idle(2);
        busCycle(16'h4000, 1'b1, 8'h00, 1'b0);
        checkOutput("romcs", PARAM_ROMCS_OUT, 0);
        idle(2);
        busCycle(16'h0FFF, 1'b1, 8'h00, 1'b0);
        checkOutput("ramcs", RAMCS_OUT, 0);
        idle(2);
        busCycle(16'hC000, 1'b1, 8'h00, 1'b0);
        checkOutput("none_sel", {RAMCS_OUT, PARAM_ROMCS_OUT, IO8_OUT, IO7_OUT, IO6_OUT,
                                 IO5_OUT, IO4_OUT, IO3_OUT, IO2_OUT}, 9'h1FF);
        idle(2);
        busCycle(16'h2010, 1'b0, 8'h5A, 1'b0);
        checkOutput("ic13_latch", RIC13_D_OUT, 8'h5A);
        idle(2);

        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1);
            if (P1_TOVERFLOW === 1'b1) pulses++;
            applyStimulus(1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
            if (P1_TOVERFLOW === 1'b1) pulses++;
        end
        checkOutput("tovf_pulses", pulses, 1);
        checkOutput("irq_after_fsync", IRQ_OUT, 0);
        checkOutput("f13_wrapped", RIC12_A_OUT[7:4], 4'h0);

        busCycle(16'h2700, 1'b1, 8'h00, 1'b0);
        checkOutput("irq_ack", IRQ_OUT, 1);
        idle(2);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1);
        idle(1);
        checkOutput("irq_set_again", IRQ_OUT, 0);
        busCycle(16'h27FF, 1'b1, 8'h00, 1'b1);
        checkOutput("irq_ack_wins", IRQ_OUT, 1);
        idle(2);

        busCycle(16'h1005, 1'b1, 8'h00, 1'b0);
        RESET_IN = 1;
        idle(1);
        checkOutput("midrst_oe", RIC12_OE_OUT, 1);
        checkOutput("midrst_p3_out", CPU_P3_OUT, 8'h00);
        checkOutput("midrst_a", RIC12_A_OUT, 11'h000);
        RESET_IN = 0;
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ic19_gate_array.md
# ic19_gate_array

Custom gate array of the piano sound board: sits between the multiplexed-bus CPU (P3 = address-low/data, P4 = address-high), the 2 KB wave-work SRAM IC12, the sample latch IC13 and the board I/O strobes. Latches the low address, decodes chip selects and I/O strobes, arbitrates IC12 between CPU accesses and a frame-synchronous scan counter, and raises the frame IRQ.

## Interface
- No parameters.
- SYNC_IN  in  1  sole clock; all logic on rising edge
- RESET_IN  in  1  synchronous reset, active-high
- FSYNC_IN  in  1  frame sync, synchronous to SYNC_IN
- E_IN, RW_IN, AS_IN  in  1 each  CPU bus phase, read(1)/write(0), address strobe (active-low)
- CPU_P3_IN / CPU_P4_IN  in  8 each  address-low/data, address-high
- CPU_P3_OUT  out  8  read data to CPU; CPU_P3_IOM  out  1  0 = drive P3
- AL_IN  in  8 (ignored); AL_OUT  out  8  latched A[7:0]; AL0_IOM  out  1  0 = drive AL
- RD_OUT, WR_OUT, PARAM_ROMCS_OUT, RAMCS_OUT  out  1 each  active-low
- RIC12_D_IN  in  8; RIC12_D_OUT  out  8; RIC12_D_IOM  out  1 (1 = tri-state); RIC12_A_OUT  out  11; RIC12_OE_OUT, RIC12_WE_OUT  out  1, active-low
- RIC13_D_IN  in  8 (ignored); RIC13_D_OUT  out  8; RIC13_D_IOM  out  1
- IO2_OUT..IO8_OUT  out  1 each  active-low strobes
- IRQ_OUT  out  1  active-low; P1_TOVERFLOW  out  1  one-cycle pulse
- E_NOR_77_IN, AL_CT_76_IN, UNK_75_IN, UNK_74_IN  in  1  reserved, ignored
- COUNTER_OUT_C13, COUNTER_OUT_F13  out  4 each  (macro-gated)

## Operation
- Address latch: AS_IN sampled each cycle; AS falling (prev 1, now 0) loads ADDR <= {CPU_P4_IN, CPU_P3_IN}; AL_OUT = ADDR[7:0].
- Access active while registered E = 1. RD_OUT = ~(E & RW); WR_OUT = ~(E & ~RW).
- Decode of ADDR when E = 1: 0x0800–0x0FFF RAMCS_OUT=0; 0x1000–0x17FF IC12 window; 0x2000–0x26FF IOn=0 with n = ADDR[10:8]+2; 0x2700–0x27FF IRQ acknowledge; 0x4000–0x7FFF PARAM_ROMCS_OUT=0; else nothing selected.
- IC12 CPU access: RIC12_A_OUT = ADDR[10:0]; read: OE=0, CPU_P3_OUT = RIC12_D_IN, CPU_P3_IOM=0; write: WE=0, RIC12_D_IOM=0, RIC12_D_OUT = CPU_P3_IN.
- IC12 idle (no CPU IC12 access): scan read, RIC12_A_OUT = {3'b111, F13, C13}, OE=0, WE=1, D_IOM=1.
- C13: 4-bit, +1 every cycle, wraps. F13: 4-bit, +1 on FSYNC rising edge, wraps; 15→0 pulses P1_TOVERFLOW for one cycle.
- IRQ_OUT set to 0 on FSYNC rising edge; set to 1 by any access to 0x2700–0x27FF; simultaneous set and ack → ack wins (IRQ=1).
- CPU write to IO2 range (0x2000–0x20FF) loads RIC13_D_OUT <= CPU_P3_IN. RIC13_D_IOM=0 outside reset.
- CPU_P3_IOM=1 except IC12 CPU read.

## Timing
- All outputs registered: one SYNC_IN cycle after the sampled inputs causing them.
- ADDR valid one cycle after AS fall; decode outputs one further cycle.
- Reset values: AL_OUT=00, CPU_P3_OUT=00, RIC12_A_OUT=000, RIC12_D_OUT=00, RIC13_D_OUT=00, C13=F13=0, all active-low outputs=1, P1_TOVERFLOW=0, CPU_P3_IOM=RIC12_D_IOM=1, AL0_IOM=0, RIC13_D_IOM=1 during reset then 0.
- Reset mid-access aborts it; outputs return to reset values the next edge.
- E fall ends the access; idle scan resumes next cycle.

## Configuration
- IC19_DEBUG_COUNTERS_EN defined: COUNTER_OUT_C13/F13 ports present, driven by C13/F13. Undefined: ports absent; counters still internal.

## Structure
- Package ic19_pkg: address-range constants, IC12 scan prefix 3'b111, counter width 4.
- One sub-module: ic19_addr_decode (combinational ADDR/E/RW → selects, IO strobes).

## Test plan
- Reset asserted → every output at reset values; release → C13 counts 0,1,2… per cycle.
- AS fall with 0x1005, E=1, RW=1 → RIC12_A_OUT=0x005, OE=0, CPU_P3_OUT=RIC12_D_IN, AL_OUT=0x05.
- 0x1005 write data 0xA5 → WE=0, RIC12_D_IOM=0, RIC12_D_OUT=0xA5, WR_OUT=0.
- 0x2000 / 0x2300 / 0x4000 / 0xC000 → IO2=0 / IO5=0 / PARAM_ROMCS=0 / nothing asserted.
- 16 FSYNC rising edges → F13 wraps to 0, one P1_TOVERFLOW pulse, IRQ_OUT=0 until 0x2700 access.
- E=0 → scan address {111,F13,C13}, OE=0, CPU_P3_IOM=1.
